// File: rtl/mul_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_add_if
//  Description : Handshake/operand bundle for the mul_add sequential
//                multiply-accumulate unit.
//                master : drives start, a, b, c; observes prod, cal, done
//                slave  : the mul_add datapath itself
//  Signals     : start - start request
//                a/b/c - multiplicand, multiplier, addend (WIDTH bits)
//                prod  - a*b + c (2*WIDTH bits)
//                cal   - calculation in progress
//                done  - single-cycle result-valid pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_add_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [2*WIDTH-1:0]   prod;
    logic                 cal;
    logic                 done;

    modport master (
        output start, a, b, c,
        input  prod, cal, done
    );

    modport slave (
        input  start, a, b, c,
        output prod, cal, done
    );
endinterface
`default_nettype wire

// File: rtl/mul_add.sv
`default_nettype none
// ============================================================================
//  Module      : mul_add
//  Description : Sequential shift-add multiply-accumulate, prod = a*b + c,
//                one multiplier bit per clock (LSB first). Rebuilds a
//                dividend from a divider's quotient, divisor and remainder,
//                using the same start/cal/done handshake as the divider.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - mul_add_if.slave (start, a, b, c in; prod, cal,
//                       done out)
//  Options     : MUL_ADD_EARLY_EN - when defined, CALC ends as soon as the
//                remaining multiplier bits are all zero (result unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_add #(
    parameter int WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mul_add_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 cal_q, cal_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]     w_mplr_step;
    logic [CNT_W-1:0]     w_cnt_step;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_res;

    // Right-shifting product register {hi, lo}. hi is preloaded with c and
    // lo with b: after WIDTH shifts c lands at weight 2^0 and the b bits
    // fall off the bottom, so the addend costs no extra adder. The sum is
    // WIDTH+1 bits so the carry out of each add is shifted in, not lost.
    always_comb begin
        w_sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (mplr_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        w_acc_step  = {w_sum, acc_q[WIDTH-1:1]};
        w_mplr_step = mplr_q >> 1;
        w_cnt_step  = cnt_q + 1'b1;
`ifdef MUL_ADD_EARLY_EN
        // Remaining multiplier bits are zero, so the outstanding steps would
        // only shift; apply those shifts at once instead.
        w_last      = (w_cnt_step == CNT_W'(WIDTH)) || (w_mplr_step == '0);
        w_res       = w_acc_step >> (CNT_W'(WIDTH) - w_cnt_step);
`else
        w_last      = (w_cnt_step == CNT_W'(WIDTH));
        w_res       = w_acc_step;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        cal_d   = cal_q;
        done_d  = done_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (bus.start) begin
                    state_d = c_CALC;
                    a_d     = bus.a;
                    mplr_d  = bus.b;
                    acc_d   = {bus.c, bus.b};
                    cnt_d   = '0;
                    cal_d   = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    state_d = c_IDLE;
                    cal_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end
            c_CALC: begin
                // start is deliberately ignored here
                acc_d  = w_acc_step;
                mplr_d = w_mplr_step;
                cnt_d  = w_cnt_step;
                if (w_last) begin
                    state_d = c_DONE;
                    prod_d  = w_res;
                    cal_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = c_IDLE;
                cal_d   = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
            a_q     <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            cal_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            cal_q   <= cal_d;
            done_q  <= done_d;
        end
    end

    assign bus.prod = prod_q;
    assign bus.cal  = cal_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_add
//  Description : Self-checking bench for mul_add (WIDTH=8): vector table of
//                {a, b, c, expected prod} plus directed sequences for reset,
//                busy start, mid-operation reset and back-to-back starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_add;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] prev_prod;

    mul_add_if #(.WIDTH(8)) bus ();

    mul_add #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [7:0] b);
        int l;
        l = 8;
`ifdef MUL_ADD_EARLY_EN
        l = 1;
        for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`endif
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands and a one-cycle start; returns just after the accept edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.a = a; bus.b = b; bus.c = c; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // scramble operands: they must not affect the running calculation
        bus.a = ~a; bus.b = ~b; bus.c = ~c;
    endtask

    // Called just after the accept edge; returns just after the done edge.
    task automatic finish_op(input string name, input logic [7:0] b, input logic [15:0] exp);
        int n;
        chk({name, " cal after accept"}, 32'(bus.cal), 32'd1);
        chk({name, " prod held in CALC"}, 32'(bus.prod), 32'(prev_prod));
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk({name, " done timeout"}, 32'(n), 32'(exp_lat(b)));
        chk({name, " latency"}, 32'(n), 32'(exp_lat(b)));
        chk({name, " prod"}, 32'(bus.prod), 32'(exp));
        chk({name, " cal low in DONE"}, 32'(bus.cal), 32'd0);
        prev_prod = exp;
    endtask

    task automatic idle_after(input string name);
        tick();
        chk({name, " done single pulse"}, 32'(bus.done), 32'd0);
        chk({name, " prod held"}, 32'(bus.prod), 32'(prev_prod));
    endtask

    task automatic no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        chk({name, " no stray done"}, 32'(seen), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        errors = 0;
        checks = 0;
        prev_prod = 16'd0;
        bus.start = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0; bus.c = 8'd0;

        vecs[0] = '{a: 8'd10,  b: 8'd10,  c: 8'd9,   exp: 16'd109};
        vecs[1] = '{a: 8'd21,  b: 8'd5,   c: 8'd4,   exp: 16'd109};
        vecs[2] = '{a: 8'hFF,  b: 8'hFF,  c: 8'hFF,  exp: 16'hFF00};
        vecs[3] = '{a: 8'd0,   b: 8'd77,  c: 8'd5,   exp: 16'd5};
        vecs[4] = '{a: 8'd77,  b: 8'd0,   c: 8'd5,   exp: 16'd5};
        vecs[5] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   exp: 16'd0};
        vecs[6] = '{a: 8'd9,   b: 8'd1,   c: 8'd0,   exp: 16'd9};
        vecs[7] = '{a: 8'd13,  b: 8'h80,  c: 8'd7,   exp: 16'd1671};
        vecs[8] = '{a: 8'd200, b: 8'd3,   c: 8'd1,   exp: 16'd601};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("reset prod", 32'(bus.prod), 32'd0);
        chk("reset cal", 32'(bus.cal), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        no_done("reset", 12);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].c);
            finish_op($sformatf("vec%0d", i), vecs[i].b, vecs[i].exp);
            idle_after($sformatf("vec%0d", i));
        end

        // Busy start ignored: a second start while in CALC must do nothing
        launch(8'd3, 8'd5, 8'd0);
        k = (exp_lat(8'd5) > 3) ? 2 : 0;
        for (int i = 0; i < k; i++) tick();
        bus.a = 8'd7; bus.b = 8'd5; bus.c = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        begin
            int n;
            n = k + 1;
            while (bus.done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("busy latency", 32'(n), 32'(exp_lat(8'd5)));
            chk("busy prod", 32'(bus.prod), 32'd15);
            prev_prod = 16'd15;
        end
        no_done("busy", 14);

        // Mid-operation reset
        launch(8'd200, 8'd3, 8'd1);
        k = (exp_lat(8'd3) > 4) ? 3 : exp_lat(8'd3) - 2;
        for (int i = 0; i < k; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst prod", 32'(bus.prod), 32'd0);
        chk("midrst cal", 32'(bus.cal), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b0;
        prev_prod = 16'd0;
        no_done("midrst", 12);
        launch(8'd2, 8'd2, 8'd0);
        finish_op("after rst", 8'd2, 16'd4);
        idle_after("after rst");

        // Back-to-back: start held through DONE accepts the next operands
        launch(8'd5, 8'd5, 8'd0);
        finish_op("b2b first", 8'd5, 16'd25);
        bus.a = 8'd6; bus.b = 8'd7; bus.c = 8'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0; bus.c = 8'd0;
        chk("b2b done dropped", 32'(bus.done), 32'd0);
        finish_op("b2b second", 8'd7, 16'd43);
        idle_after("b2b second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
